// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, ALU opcode encodings and reset defaults
// used by the fetch unit, ALU and decoder.
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [5:0] OP_BEQ  = 6'd29;
    localparam logic [5:0] OP_BNE  = 6'd30;
    localparam logic [5:0] OP_BLT  = 6'd31;
    localparam logic [5:0] OP_BGE  = 6'd32;
    localparam logic [5:0] OP_BLTU = 6'd33;
    localparam logic [5:0] OP_BGEU = 6'd34;
    localparam logic [5:0] OP_JALR = 6'd35;
    localparam logic [5:0] OP_JAL  = 6'd36;

    // Conditional branches occupy one contiguous opcode range.
    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection from the retiring instruction's ALU outcome,
// plus the sequential link value and a misaligned-target flag.
module next_pc_sel
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [5:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] br_imm,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    logic [XLEN-1:0] seq_pc_s;

    assign seq_pc_s = pc + {{(XLEN-3){1'b0}}, 3'b100};
    assign pc_plus4 = seq_pc_s;
    assign misalign = (next_pc[1:0] != 2'b00);

    // Target mux: branch taken flag lives in alu_result[0]; jalr clears bit 0.
    always_comb begin
        next_pc = seq_pc_s;
        if (is_branch(alu_opcode)) begin
            if (alu_result[0]) begin
                next_pc = pc + br_imm;
            end else begin
                next_pc = seq_pc_s;
            end
        end else begin
            case (alu_opcode)
                OP_JALR: next_pc = {alu_result[XLEN-1:1], 1'b0};
                OP_JAL:  next_pc = alu_result;
                default: next_pc = seq_pc_s;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch over a valid/ready imem port;
// halts with a sticky fault when a retiring instruction targets a misaligned address.
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            exec_done,
    input  logic [5:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] br_imm,
    output logic            fault
);

    fetch_state_e    state_r;
    fetch_state_e    state_s;
    logic            guard_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     instr_r;
    logic            fault_r;
    logic            req_valid_s;
    logic            instr_valid_s;
    logic            issue_done_s;
    logic [XLEN-1:0] next_pc_s;
    logic            misalign_s;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc         (pc_r),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .br_imm     (br_imm),
        .next_pc    (next_pc_s),
        .pc_plus4   (pc_plus4),
        .misalign   (misalign_s)
    );

    assign issue_done_s = (state_r == ST_ISSUE) && exec_done;

    // State register; guard_r masks the request for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_REQ;
            guard_r <= 1'b1;
        end else begin
            state_r <= state_s;
            guard_r <= 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (req_valid_s && imem_req_ready) state_s = ST_WAIT;
                else                               state_s = ST_REQ;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) state_s = ST_ISSUE;
                else                state_s = ST_WAIT;
            end
            ST_ISSUE: begin
                if (exec_done) state_s = misalign_s ? ST_HALT : ST_REQ;
                else           state_s = ST_ISSUE;
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_REQ;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        req_valid_s   = 1'b0;
        instr_valid_s = 1'b0;
        case (state_r)
            ST_REQ:   req_valid_s   = !guard_r;
            ST_ISSUE: instr_valid_s = 1'b1;
            default: begin
                req_valid_s   = 1'b0;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    // PC, instruction capture and sticky fault; a misaligned target leaves pc untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            fault_r <= 1'b0;
        end else begin
            if ((state_r == ST_WAIT) && imem_rsp_valid) begin
                instr_r <= imem_rsp_data;
            end else begin
                instr_r <= instr_r;
            end
            if (issue_done_s) begin
                if (misalign_s) begin
                    fault_r <= 1'b1;
                end else begin
                    pc_r <= next_pc_s;
                end
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_r;
    assign instr_valid    = instr_valid_s;
    assign instr          = instr_r;
    assign pc             = pc_r;
    assign fault          = fault_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: expected fetch addresses are queued when an
// instruction retires and compared when the next imem request appears.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_result;
    logic [31:0] br_imm;
    logic        fault;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cur_accept = 0;
    int last_accept = 0;
    logic [31:0] exp_q[$];

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .exec_done      (exec_done),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .br_imm         (br_imm),
        .fault          (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [5:0] op,
                                               input logic [31:0] res, input logic [31:0] imm);
        if (op >= 6'd29 && op <= 6'd34) return res[0] ? p + imm : p + 32'd4;
        else if (op == 6'd35)           return res & 32'hFFFF_FFFE;
        else if (op == 6'd36)           return res;
        else                            return p + 32'd4;
    endfunction

    // One full fetch/issue/retire round trip with configurable imem and execute delays.
    task automatic fetch_one(input int rdy_dly, input int rsp_dly, input int ex_dly,
                             input logic [5:0] op, input logic [31:0] res, input logic [31:0] imm);
        logic [31:0] a;
        logic [31:0] nxt;
        int n;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: imem_req_valid=%b required 1 within 50 cycles", imem_req_valid);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_req: addr=%h with no expected fetch queued", imem_addr);
            return;
        end
        a = exp_q.pop_front();
        if (imem_addr !== a) begin
            failures++;
            $display("FAIL req_addr: got %h required %h", imem_addr, a);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== a) begin
                failures++;
                $display("FAIL req_hold: valid=%b addr=%h required 1/%h", imem_req_valid, imem_addr, a);
            end
        end
        imem_req_ready = 1'b1;
        last_accept = cur_accept;
        cur_accept = cyc;
        @(negedge clk);
        imem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            checks++;
            if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_idle: instr_valid=%b req_valid=%b required 0/0", instr_valid, imem_req_valid);
            end
            @(negedge clk);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data = pat(a);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        for (int i = 0; i <= ex_dly; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== pat(a) || pc !== a || pc_plus4 !== a + 32'd4) begin
                failures++;
                $display("FAIL issue: valid=%b instr=%h pc=%h pc4=%h required 1/%h/%h/%h",
                         instr_valid, instr, pc, pc_plus4, pat(a), a, a + 32'd4);
            end
            if (i < ex_dly) @(negedge clk);
        end
        exec_done = 1'b1;
        alu_opcode = op;
        alu_result = res;
        br_imm = imm;
        nxt = model_next(a, op, res, imm);
        if (nxt[1:0] == 2'b00) exp_q.push_back(nxt);
        @(negedge clk);
        exec_done = 1'b0;
        alu_opcode = 6'd0;
        checks++;
        if (fault !== (nxt[1:0] != 2'b00)) begin
            failures++;
            $display("FAIL fault_flag: got %b required %b (target %h)", fault, (nxt[1:0] != 2'b00), nxt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        exec_done = 1'b0;
        alu_opcode = 6'd0;
        alu_result = 32'h0;
        br_imm = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 32'h0 || fault !== 1'b0 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: pc=%h fault=%b iv=%b rv=%b instr=%h required 0", pc, fault, instr_valid, imem_req_valid, instr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_guard: req_valid=%b required 0", imem_req_valid);
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req: valid=%b addr=%h required 1/0", imem_req_valid, imem_addr);
        end
        // Accept the request, then reset while the response is outstanding.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait: rv=%b iv=%b pc=%h fault=%b required 0/0/0/0", imem_req_valid, instr_valid, pc, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_guard2: req_valid=%b required 0", imem_req_valid);
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL stale_rsp: instr=%h iv=%b rv=%b addr=%h required 0/0/1/0", instr, instr_valid, imem_req_valid, imem_addr);
        end
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            fetch_one(0, 0, 0, 6'd5, 32'h1234_5671, 32'h0000_0100);
            if (i > 0) begin
                checks++;
                if (cur_accept - last_accept != 3) begin
                    failures++;
                    $display("FAIL loop_cycles: got %0d required 3", cur_accept - last_accept);
                end
            end
        end
    endtask

    task automatic test_branch();
        fetch_one(0, 0, 0, 6'd29, 32'h0000_0001, 32'hFFFF_FFF8);
        fetch_one(0, 0, 0, 6'd5,  32'h0000_0000, 32'h0000_0000);
        fetch_one(0, 0, 0, 6'd5,  32'h0000_0000, 32'h0000_0000);
        fetch_one(0, 0, 0, 6'd29, 32'h0000_0000, 32'hFFFF_FFF8);
        fetch_one(0, 0, 0, 6'd28, 32'h0000_0001, 32'h0000_0100);
        fetch_one(0, 0, 0, 6'd34, 32'h0000_0001, 32'h0000_0020);
        fetch_one(0, 0, 0, 6'd30, 32'hFFFF_FFFE, 32'h0000_0040);
    endtask

    task automatic test_jal();
        fetch_one(0, 0, 0, 6'd36, 32'h0000_0400, 32'h0000_0000);
    endtask

    task automatic test_backpressure();
        fetch_one(5, 3, 2, 6'd5, 32'h0000_0000, 32'h0000_0000);
    endtask

    task automatic test_wrap_and_jalr();
        fetch_one(0, 0, 0, 6'd36, 32'hFFFF_FFFC, 32'h0000_0000);
        fetch_one(1, 1, 0, 6'd5,  32'h0000_0000, 32'h0000_0000);
        fetch_one(0, 0, 0, 6'd35, 32'h0000_2001, 32'h0000_0000);
        fetch_one(0, 0, 0, 6'd35, 32'h0000_2003, 32'h0000_0000);
    endtask

    task automatic test_halt();
        for (int i = 0; i < 10; i++) begin
            exec_done = (i % 3 == 0);
            imem_req_ready = 1'b1;
            imem_rsp_valid = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1 || pc !== 32'h0000_2000) begin
                failures++;
                $display("FAIL halt: rv=%b iv=%b fault=%b pc=%h required 0/0/1/00002000", imem_req_valid, instr_valid, fault, pc);
            end
        end
        exec_done = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expect: %0d fetches never requested", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_backpressure();
        test_wrap_and_jalr();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
